// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// Handshakes: the datapath holds imemREN/imemaddr and takes the word in the
// cycle ihit is high; the cache holds iREN/iaddr steady until the memory
// drops iwait, and iload is consumed on that same clock edge.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic        dbg_fetch;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count, dbg_fetch
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count, dbg_fetch
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a two-state
// miss handler and saturating hit/miss counters.
module icache #(
  parameter int NSETS = 16
) (
  input logic       CLK,
  input logic       nRST,
  icache_if.slave   bus
);
  localparam int IW = $clog2(NSETS);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t          state_q;
  logic            valid_q [NSETS];
  logic [TW-1:0]   tag_q   [NSETS];
  logic [31:0]     data_q  [NSETS];
  logic [29:0]     faddr_q;
  logic            iren_q;
  logic [31:0]     iaddr_q;
  logic [15:0]     hit_count_q, hit_count_d;
  logic [15:0]     miss_count_q, miss_count_d;

  logic [IW-1:0]   req_idx, fill_idx;
  logic [TW-1:0]   req_tag, fill_tag;
  logic            hit, miss;
  logic            unused_offset;

  assign req_idx  = bus.imemaddr[IW+1:2];
  assign req_tag  = bus.imemaddr[31:IW+2];
  assign fill_idx = faddr_q[IW-1:0];
  assign fill_tag = faddr_q[29:IW];
  // Byte offset within the word never affects the lookup.
  assign unused_offset = ^bus.imemaddr[1:0];

  // Lookup: a hit is only possible while idle with a live request.
  always_comb begin
    hit  = 1'b0;
    miss = 1'b0;
    if (state_q == IDLE && bus.imemREN) begin
      hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
      miss = !hit;
    end
  end

  // Saturating counter next values.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit && hit_count_q != 16'hFFFF)
      hit_count_d = hit_count_q + 16'd1;
    if (miss && miss_count_q != 16'hFFFF)
      miss_count_d = miss_count_q + 16'd1;
  end

  // Miss FSM, frame fill and counters; memory-side outputs are registered.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      faddr_q      <= '0;
      iren_q       <= 1'b0;
      iaddr_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      for (int i = 0; i < NSETS; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      case (state_q)
        IDLE: begin
          if (miss) begin
            faddr_q <= bus.imemaddr[31:2];
            iaddr_q <= {bus.imemaddr[31:2], 2'b00};
            iren_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          // The fill targets the latched address regardless of what the
          // datapath is presenting now.
          if (!bus.iwait) begin
            valid_q[fill_idx] <= 1'b1;
            tag_q[fill_idx]   <= fill_tag;
            data_q[fill_idx]  <= bus.iload;
            iren_q            <= 1'b0;
            iaddr_q           <= '0;
            state_q           <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ihit       = hit;
  assign bus.imemload   = hit ? data_q[req_idx] : 32'h0;
  assign bus.iREN       = iren_q;
  assign bus.iaddr      = iaddr_q;
  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;
  assign bus.dbg_fetch  = (state_q == FETCH);
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a memory responder, a cycle-level model of the
// cache contents checked every cycle, and hand-computed scenario checks.
module tb_icache;
  localparam int NSETS = 16;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  icache_if bus();
  icache #(.NSETS(NSETS)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [31:0] mem [logic [31:0]];
  int mem_waits = 0;

  function automatic logic [31:0] mem_value(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  initial begin
    int cnt;
    logic prev;
    cnt = 0;
    prev = 1'b0;
    bus.iwait = 1'b1;
    bus.iload = 32'h0;
    forever begin
      @(posedge CLK);
      #1;
      if (bus.iREN) begin
        if (!prev) cnt = mem_waits;
        if (cnt > 0) begin
          bus.iwait = 1'b1;
          bus.iload = $urandom;
          cnt--;
        end else begin
          bus.iwait = 1'b0;
          bus.iload = mem_value(bus.iaddr);
        end
      end else begin
        bus.iwait = 1'b1;
        bus.iload = $urandom;
      end
      prev = bus.iREN;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  bit          m_valid [NSETS];
  logic [29:0] m_word  [NSETS];
  logic [31:0] m_data  [NSETS];
  bit          m_fetch;
  logic [29:0] m_fw;
  int          m_hits, m_misses;

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : v[15:0];
  endfunction

  initial begin
    int unsigned wa;
    int idx;
    bit exp_hit;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        for (int i = 0; i < NSETS; i++) begin
          m_valid[i] = 0; m_word[i] = '0; m_data[i] = '0;
        end
        m_fetch = 0; m_fw = '0; m_hits = 0; m_misses = 0;
        check("rst_ihit", {31'b0, bus.ihit}, 32'h0);
        check("rst_imemload", bus.imemload, 32'h0);
        check("rst_iREN", {31'b0, bus.iREN}, 32'h0);
        check("rst_iaddr", bus.iaddr, 32'h0);
        check("rst_hits", {16'h0, bus.hit_count}, 32'h0);
        check("rst_misses", {16'h0, bus.miss_count}, 32'h0);
      end else begin
        wa = bus.imemaddr >> 2;
        idx = int'(wa % NSETS);
        exp_hit = !m_fetch && bus.imemREN && m_valid[idx] && (m_word[idx] == wa[29:0]);
        check("cyc_ihit", {31'b0, bus.ihit}, {31'b0, exp_hit});
        check("cyc_imemload", bus.imemload, exp_hit ? m_data[idx] : 32'h0);
        check("cyc_iREN", {31'b0, bus.iREN}, {31'b0, m_fetch});
        check("cyc_iaddr", bus.iaddr, m_fetch ? {m_fw, 2'b00} : 32'h0);
        check("cyc_hits", {16'h0, bus.hit_count}, {16'h0, sat16(m_hits)});
        check("cyc_misses", {16'h0, bus.miss_count}, {16'h0, sat16(m_misses)});
        check("cyc_no_hit_and_ren", {31'b0, bus.ihit & bus.iREN}, 32'h0);
        // Advance the model to what the next edge must produce.
        if (m_fetch) begin
          if (!bus.iwait) begin
            m_valid[int'(m_fw) % NSETS] = 1;
            m_word[int'(m_fw) % NSETS]  = m_fw;
            m_data[int'(m_fw) % NSETS]  = bus.iload;
            m_fetch = 0;
          end
        end else if (bus.imemREN) begin
          if (exp_hit) m_hits++;
          else begin
            m_fetch = 1;
            m_fw = wa[29:0];
            m_misses++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks (enter/exit at posedge+1) ----------------
  task automatic access(input logic [31:0] a, input int waits,
                        output int iren_cyc, output logic [31:0] first_iaddr,
                        output logic [31:0] load);
    bit got;
    logic [31:0] e;
    got = 0; iren_cyc = 0; first_iaddr = 32'h0; load = 32'h0;
    mem_waits = waits;
    exp_q.push_back(mem_value({a[31:2], 2'b00}));
    bus.imemaddr = a;
    bus.imemREN = 1'b1;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge CLK);
      if (bus.ihit) begin
        got = 1;
        load = bus.imemload;
      end else if (bus.iREN) begin
        if (iren_cyc == 0) first_iaddr = bus.iaddr;
        iren_cyc++;
      end
    end
    check("access_completed", {31'b0, got}, 32'h1);
    e = exp_q.pop_front();
    check("access_load", load, e);
    @(posedge CLK);
    #1;
    bus.imemREN = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    bus.imemREN = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    bit got;
    logic [31:0] fa, ld;
    logic [31:0] idle_addrs [4];
    bus.imemREN = 1'b0;
    bus.imemaddr = 32'h0;
    mem[32'h40] = 32'h8C22_0004;
    idle_addrs[0] = 32'h40; idle_addrs[1] = 32'h0;
    idle_addrs[2] = 32'h123; idle_addrs[3] = 32'hFFFF_FFFC;

    @(negedge CLK);
    check("reset_iREN", {31'b0, bus.iREN}, 32'h0);
    check("reset_ihit", {31'b0, bus.ihit}, 32'h0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // Cold miss at 0x40: two busy cycles then data.
    access(32'h40, 2, n, fa, ld);
    check("cold_iren_cycles", n, 3);
    check("cold_iaddr", fa, 32'h40);
    check("cold_load", ld, 32'h8C22_0004);
    @(negedge CLK);
    check("cold_miss_count", {16'h0, bus.miss_count}, 32'd1);
    check("cold_hit_count", {16'h0, bus.hit_count}, 32'd1);
    @(posedge CLK);
    #1;

    // Conflict on index 0: 0x0, 0x40, 0x0 all miss, then 0x0 hits.
    do_reset();
    access(32'h0, 0, n, fa, ld);
    check("conf_a_miss", n, 1);
    access(32'h40, 1, n, fa, ld);
    check("conf_b_miss", n, 2);
    access(32'h0, 0, n, fa, ld);
    check("conf_a_again_miss", n, 1);
    @(negedge CLK);
    check("conf_miss_count", {16'h0, bus.miss_count}, 32'd3);
    @(posedge CLK);
    #1;
    access(32'h0, 0, n, fa, ld);
    check("conf_a_now_hits", n, 0);

    // Address change mid-fill: fill of 0x10 must complete unchanged.
    mem_waits = 3;
    bus.imemaddr = 32'h10;
    bus.imemREN = 1'b1;
    @(posedge CLK);
    #1;
    check("redir_iaddr_start", bus.iaddr, 32'h10);
    bus.imemaddr = 32'h20;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (!bus.iREN) break;
      check("redir_iaddr_held", bus.iaddr, 32'h10);
    end
    check("redir_0x20_not_hit", {31'b0, bus.ihit}, 32'h0);
    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge CLK);
      if (bus.ihit) got = 1;
    end
    check("redir_0x20_filled", {31'b0, got}, 32'h1);
    @(posedge CLK);
    #1;
    bus.imemREN = 1'b0;
    access(32'h10, 0, n, fa, ld);
    check("redir_0x10_hits", n, 0);

    // Reset in the middle of a fill.
    do_reset();
    access(32'h40, 1, n, fa, ld);
    access(32'h40, 0, n, fa, ld);
    check("rstmid_warm_hit", n, 0);
    mem_waits = 5;
    bus.imemaddr = 32'h80;
    bus.imemREN = 1'b1;
    @(posedge CLK);
    #1;
    check("rstmid_iren_up", {31'b0, bus.iREN}, 32'h1);
    nRST = 1'b0;
    bus.imemREN = 1'b0;
    #1;
    check("rstmid_iren_async", {31'b0, bus.iREN}, 32'h0);
    check("rstmid_iaddr_async", bus.iaddr, 32'h0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    access(32'h40, 0, n, fa, ld);
    check("rstmid_0x40_misses", n, 1);
    @(negedge CLK);
    check("rstmid_miss_count", {16'h0, bus.miss_count}, 32'd1);
    @(posedge CLK);
    #1;

    // Saturation: 70000 back-to-back hit cycles on 0x40.
    bus.imemaddr = 32'h40;
    bus.imemREN = 1'b1;
    repeat (70000) @(posedge CLK);
    #1;
    bus.imemREN = 1'b0;
    @(negedge CLK);
    check("sat_hit_count", {16'h0, bus.hit_count}, 32'h0000_FFFF);
    check("sat_miss_count", {16'h0, bus.miss_count}, 32'd1);
    @(posedge CLK);
    #1;

    // Idle: no request means no hit, no fetch, no counting.
    foreach (idle_addrs[k]) begin
      bus.imemaddr = idle_addrs[k];
      @(negedge CLK);
      check("idle_ihit", {31'b0, bus.ihit}, 32'h0);
      check("idle_iREN", {31'b0, bus.iREN}, 32'h0);
      check("idle_hits", {16'h0, bus.hit_count}, 32'h0000_FFFF);
      check("idle_misses", {16'h0, bus.miss_count}, 32'd1);
      @(posedge CLK);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound.
  initial begin
    #5_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter NSETS, default 16, number of direct-mapped one-word frames (power of two, 2..64).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port imemREN  input  1  datapath fetch request.
REQ-005 SHALL have port imemaddr  input  32  datapath fetch byte address (PC).
REQ-006 SHALL have port ihit  output  1  requested word valid on imemload this cycle.
REQ-007 SHALL have port imemload  output  32  instruction word returned to datapath.
REQ-008 SHALL have port iREN  output  1  memory-side read request.
REQ-009 SHALL have port iaddr  output  32  memory-side word address.
REQ-010 SHALL have port iwait  input  1  memory busy; low means iload is valid this cycle.
REQ-011 SHALL have port iload  input  32  memory read data.
REQ-012 SHALL have port hit_count  output  16  saturating count of hit cycles.
REQ-013 SHALL have port miss_count  output  16  saturating count of misses started.

Function
REQ-014 SHALL split imemaddr as offset [1:0] (ignored), index [log2(NSETS)+1:2], tag = remaining upper bits.
REQ-015 SHALL hold per frame: valid bit, tag, 32-bit data.
REQ-016 SHALL assert ihit combinationally when state=IDLE, imemREN=1, valid[index]=1 and stored tag equals address tag; imemload = frame data that cycle.
REQ-017 SHALL drive imemload=0 and ihit=0 whenever a hit is not asserted.
REQ-018 SHALL implement FSM states IDLE and FETCH only.
REQ-019 IDLE: imemREN=1 and miss -> latch faddr={imemaddr[31:2],2'b00}, increment miss_count, go FETCH next edge; iREN=0 in IDLE.
REQ-020 IDLE: imemREN=0 -> stay IDLE, no counter change, iREN=0.
REQ-021 FETCH: iREN=1, iaddr=faddr; ihit=0 throughout FETCH.
REQ-022 FETCH with iwait=1 -> remain FETCH, no frame write.
REQ-023 FETCH with iwait=0 -> on that edge write frame[faddr index] valid=1, tag=faddr tag, data=iload; go IDLE.
REQ-024 Requested word SHALL hit in the first IDLE cycle after fill; miss latency = 1 (IDLE detect) + FETCH cycles until iwait low + 1 (hit cycle).
REQ-025 Fetch SHALL use latched faddr; changes to imemaddr or imemREN dropping during FETCH SHALL NOT abort or redirect the fill.
REQ-026 A fill SHALL overwrite any previous valid frame at that index (no replacement choice).
REQ-027 iaddr SHALL be 0 outside FETCH.
REQ-028 hit_count SHALL increment by 1 each cycle ihit=1; miss_count per REQ-019; both saturate at 16'hFFFF, no wrap.
REQ-029 Block SHALL never issue iREN in the same cycle a hit is signalled.

Reset
REQ-030 nRST low SHALL immediately force state=IDLE, all valid bits=0, tags and data=0, faddr=0, hit_count=0, miss_count=0.
REQ-031 Outputs during and after reset: ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-032 Reset asserted mid-FETCH SHALL abandon the fill with no frame written; first request after release misses.

Verification
REQ-033 Cold miss: after reset, imemREN=1, imemaddr=0x00000040, iwait=1 for 2 cycles then 0 with iload=0x8C220004 -> iREN high 3 cycles, iaddr=0x40, next cycle ihit=1, imemload=0x8C220004, miss_count=1, hit_count=1.
REQ-034 Conflict: fill 0x00000000 then request 0x00000040 (same index, NSETS=16) -> miss, refill; subsequent 0x00000000 misses again; miss_count=3.
REQ-035 Address change mid-FETCH: start miss at 0x10, switch imemaddr to 0x20 before iwait low -> iaddr stays 0x10, frame for 0x10 filled, 0x20 then misses.
REQ-036 Reset mid-FETCH: pull nRST low while iREN=1 -> iREN=0 asynchronously; after release, previously hit address 0x40 misses.
REQ-037 Saturation: force 70000 consecutive hit cycles -> hit_count holds 0xFFFF.
REQ-038 Idle: imemREN=0 with any address -> ihit=0, iREN=0, counters unchanged.
